// File: rtl/cam_pkg.sv
// Shared types and helpers for the parametrised CAM file.
// Index width and lowest-set-bit encoding used by every CAM encoder.
package cam_pkg;

  localparam int MAX_DEPTH = 256;
  localparam int MAX_IDX_W = 8;

  typedef logic [MAX_IDX_W-1:0] cam_idx_t;

  function automatic int idx_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  function automatic cam_idx_t lowest_set(
    input logic [MAX_DEPTH-1:0] vec
  );
    cam_idx_t idx;
    idx = '0;
    for (int i = MAX_DEPTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = cam_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-index priority encoder over a DEPTH-bit vector.
// Reports whether any bit is set and the lowest set position.
module cam_prio_enc
  import cam_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IW    = idx_w(DEPTH)
) (
  input  logic [DEPTH-1:0] vec,
  output logic             found,
  output logic [IW-1:0]    idx
);

  cam_idx_t full_idx;

  assign found    = |vec;
  assign full_idx = lowest_set(MAX_DEPTH'(vec));
  assign idx      = full_idx[IW-1:0];

  if (IW < MAX_IDX_W) begin : g_sink
    logic sink_unused;
    assign sink_unused = ^full_idx[MAX_IDX_W-1:IW];
  end

endmodule

// File: rtl/cam_file_param.sv
// Parametrised CAM file: registered lookup, handshaked insert with
// duplicate suppression, optional round-robin replace, delete, flush.
module cam_file_param
  import cam_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter int DEPTH      = 8,
  parameter int REPLACE_EN = 0,
  localparam int IW        = idx_w(DEPTH),
  localparam int OW        = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    lookup_valid,
  input  logic [DATA_W-1:0]       lookup_key,
  output logic                    hit_valid,
  output logic                    hit,
  output logic [IW-1:0]           hit_idx,
  input  logic                    ins_valid,
  input  logic [DATA_W-1:0]       ins_key,
  output logic                    ins_ready,
  output logic                    ins_ack,
  output logic                    ins_dup,
  output logic [IW-1:0]           ins_idx,
  input  logic                    del_valid,
  input  logic [DATA_W-1:0]       del_key,
  input  logic                    flush,
  output logic [OW-1:0]           occupancy,
  output logic                    full,
  output logic [DEPTH*DATA_W-1:0] entries
);

  logic [DEPTH-1:0][DATA_W-1:0] keys;
  logic [DEPTH-1:0] valid;
  logic [IW-1:0]    victim;

  logic [DEPTH-1:0] lk_vec, dup_vec, del_hits;
  logic [DEPTH-1:0] free_vec, adj_vec;
  logic             lk_found, dup_found;
  logic             free_found, adj_found;
  logic [IW-1:0]    lk_idx, dup_idx, free_idx, adj_idx;

  logic             accept, has_free;
  logic             write_new, write_rep, wr_en;
  logic [IW-1:0]    free_slot, wr_idx, res_idx;
  logic [OW-1:0]    del_cnt, occ_next;

  // Dup check ignores entries this cycle's delete removes.
  always_comb begin
    lk_vec   = '0;
    dup_vec  = '0;
    del_hits = '0;
    del_cnt  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lk_vec[i]   = valid[i] && keys[i] == lookup_key;
      del_hits[i] = del_valid && valid[i]
                    && keys[i] == del_key;
      dup_vec[i]  = valid[i] && !del_hits[i]
                    && keys[i] == ins_key;
      del_cnt     = del_cnt + OW'(del_hits[i]);
    end
  end

  assign free_vec = ~valid;
  assign adj_vec  = ~valid | del_hits;

  cam_prio_enc #(.DEPTH(DEPTH), .IW(IW)) u_lk (
    .vec(lk_vec), .found(lk_found), .idx(lk_idx)
  );

  cam_prio_enc #(.DEPTH(DEPTH), .IW(IW)) u_dup (
    .vec(dup_vec), .found(dup_found), .idx(dup_idx)
  );

  cam_prio_enc #(.DEPTH(DEPTH), .IW(IW)) u_free (
    .vec(free_vec), .found(free_found), .idx(free_idx)
  );

  cam_prio_enc #(.DEPTH(DEPTH), .IW(IW)) u_adj (
    .vec(adj_vec), .found(adj_found), .idx(adj_idx)
  );

  assign full      = occupancy == OW'(DEPTH);
  assign ins_ready = !flush && !(full && REPLACE_EN == 0);
  assign accept    = ins_valid && ins_ready;

  assign has_free  = del_valid ? adj_found : free_found;
  assign free_slot = del_valid ? adj_idx : free_idx;

  assign write_new = accept && !dup_found && has_free;
  assign write_rep = accept && !dup_found && !has_free;
  assign wr_en     = write_new || write_rep;
  assign wr_idx    = write_rep ? victim : free_slot;
  assign res_idx   = dup_found ? dup_idx : wr_idx;

  assign occ_next  = occupancy - del_cnt + OW'(write_new);
  assign entries   = keys;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keys      <= '0;
      valid     <= '0;
      victim    <= '0;
      occupancy <= '0;
      hit_valid <= 1'b0;
      hit       <= 1'b0;
      hit_idx   <= '0;
      ins_ack   <= 1'b0;
      ins_dup   <= 1'b0;
      ins_idx   <= '0;
    end else begin
      hit_valid <= lookup_valid;
      hit       <= lookup_valid && lk_found;
      hit_idx   <= (lookup_valid && lk_found) ? lk_idx : '0;
      ins_ack   <= accept;
      ins_dup   <= accept && dup_found;
      ins_idx   <= accept ? res_idx : '0;
      if (flush) begin
        valid     <= '0;
        victim    <= '0;
        occupancy <= '0;
      end else begin
        valid     <= valid & ~del_hits;
        occupancy <= occ_next;
        if (wr_en) begin
          valid[wr_idx] <= 1'b1;
          keys[wr_idx]  <= ins_key;
        end
        if (write_rep) victim <= victim + 1'b1;
      end
    end
  end

endmodule

// File: doc/cam_file_param.md
# cam_file_param

Parametrised content-addressable memory file, the next generation of the fixed 8×4-bit CAM file. Stores up to DEPTH keys of DATA_W bits. Supports registered lookups with hit index, handshaked insert with duplicate suppression and optional round-robin replacement when full, keyed delete, and flush. Sits beside the register-file blocks as a lookup table for tag/key matching.

## Interface
- DATA_W, 4: key width in bits.
- DEPTH, 8: number of entries (≥2, power of two).
- REPLACE_EN, 0: 1 = overwrite the round-robin victim when full; 0 = refuse inserts when full.
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- lookup_valid  in  1  lookup request this cycle.
- lookup_key  in  DATA_W  key to search.
- hit_valid  out  1  lookup result valid (one cycle after request).
- hit  out  1  key found.
- hit_idx  out  $clog2(DEPTH)  lowest matching index; 0 on miss.
- ins_valid  in  1  insert request.
- ins_key  in  DATA_W  key to insert.
- ins_ready  out  1  insert accepted this cycle (combinational).
- ins_ack  out  1  pulse one cycle after an accepted insert.
- ins_dup  out  1  with ins_ack: key already present, nothing written.
- ins_idx  out  $clog2(DEPTH)  with ins_ack: slot written or matched.
- del_valid  in  1  delete all entries matching del_key.
- del_key  in  DATA_W  key to delete.
- flush  in  1  invalidate all entries.
- occupancy  out  $clog2(DEPTH+1)  count of valid entries.
- full  out  1  occupancy == DEPTH.
- entries  out  DEPTH×DATA_W  entry contents for debug, packed, entry 0 in LSBs.

## Operation
- State: key[DEPTH], valid[DEPTH], victim pointer, occupancy counter, registered lookup/insert results.
- Lookup: compare lookup_key against every valid entry; register hit, lowest matching index, and hit_valid. Invalid entries never match.
- Insert accepted when ins_valid && ins_ready. ins_ready = !flush && !(full && !REPLACE_EN). Accepted insert:
  - Key matches a valid entry (lowest index): no write; ins_dup=1, ins_idx=that index.
  - Else, not full: write to the lowest-index invalid slot, set valid, occupancy+1.
  - Else (full, REPLACE_EN=1): overwrite the slot at the victim pointer, occupancy unchanged, victim pointer advances by 1 mod DEPTH.
- Delete: clears valid on all matching entries; occupancy decreases by the number cleared. A delete with no match is a no-op.
- Flush: clears all valid bits, occupancy=0, victim=0; keys are not cleared.
- Priority within a cycle: flush > delete > insert. If del_key == ins_key in the same cycle, the delete is applied and the insert is treated as a fresh (non-duplicate) insert into the freed or lowest free slot. A slot freed by a delete this cycle counts as free for an insert this cycle.
- The victim pointer advances only on replacement writes.

## Timing
- Reset (rst_n low, asynchronous): all valid=0, keys=0, occupancy=0, full=0, victim=0, hit_valid=0, hit=0, hit_idx=0, ins_ack=0, ins_dup=0, ins_idx=0; entries=0. ins_ready follows its equation (1 after reset).
- Lookup latency 1 cycle. The lookup sees contents before this cycle's insert, delete, or flush (read-before-write). Back-to-back lookups give one result per cycle.
- ins_ack, ins_dup, and ins_idx are registered, one cycle after acceptance. occupancy and full update on the same edge as the write.
- Reset asserted mid-operation drops all pending results; no ack is issued after reset.

## Structure
- Package cam_pkg: function clog2-safe index width, typedef cam_idx_t, and a function for the lowest-set-bit priority encoder.
- One sub-module, cam_prio_enc: a DEPTH-bit match/free vector in; found flag and lowest index out. Instantiated for the lookup match, insert duplicate check, free slot, and delete-adjusted free slot.

## Test plan
- Reset then lookup 4'hB → hit_valid=1, hit=0, hit_idx=0 next cycle; occupancy=0.
- Insert 4'hB, 4'h3, 4'hB → acks with ins_idx=0, 1, then 0 with ins_dup=1; occupancy=2; lookup 4'h3 → hit=1, hit_idx=1.
- Fill 8 distinct keys with REPLACE_EN=0 → full=1, ins_ready=0 for a 9th key. With REPLACE_EN=1, 9th key 4'hF → ins_idx=0, the next insert gives ins_idx=1, occupancy stays 8.
- Same cycle: del_valid with 4'h3 and ins_valid with 4'h3, and a lookup of 4'h3 → lookup hit=1 (old contents); the entry is rewritten at the lowest free slot; occupancy unchanged.
- flush during an ins_valid → ins_ready=0, no ack; occupancy=0; a later lookup of any key misses.
- Assert rst_n low asynchronously between edges with ins_ack pending → all outputs reach reset values immediately; no ack follows release.
